// File: rtl/board_history_stack.sv
// Undo-stack controller for the board-state BRAM: pushes packed board snapshots
// and pops them back through the BRAM's one-cycle registered read port.
module board_history_stack #(
    parameter int MEM_SIZE   = 256,
    parameter int DEPTH_LOG2 = 4,
    parameter bit WRAP       = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clear,
    input  logic [MEM_SIZE-1:0]   board_in,
    output logic [MEM_SIZE-1:0]   board_out,
    output logic                  board_valid,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   depth,
    output logic                  empty,
    output logic                  full,
    output logic                  err,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [MEM_SIZE-1:0]   mem_din,
    input  logic [MEM_SIZE-1:0]   mem_dout
);

    typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, DONE} state_t;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
    localparam logic [DEPTH_LOG2:0]   DEPTH_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   CAPACITY  = {1'b1, {DEPTH_LOG2{1'b0}}};

    state_t                state_q;
    logic [DEPTH_LOG2-1:0] top_q;
    logic [DEPTH_LOG2-1:0] base_q;
    logic [DEPTH_LOG2:0]   depth_q;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [MEM_SIZE-1:0]   din_q;
    logic [MEM_SIZE-1:0]   board_out_q;
    logic                  we_q;
    logic                  valid_q;
    logic                  err_q;
    logic                  is_full;
    logic                  is_empty;

    assign is_full  = (depth_q == CAPACITY);
    assign is_empty = (depth_q == '0);

    // Pulses (we/err/valid) default low every cycle; only IDLE accepts requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            top_q       <= '0;
            base_q      <= '0;
            depth_q     <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            board_out_q <= '0;
            we_q        <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            we_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        depth_q <= '0;
                        base_q  <= top_q;
                    end else if (push) begin
                        if (!is_full || WRAP) begin
                            we_q   <= 1'b1;
                            addr_q <= top_q;
                            din_q  <= board_in;
                            top_q  <= top_q + PTR_ONE;
                            // A full circular stack drops its oldest entry instead of growing.
                            if (is_full) begin
                                base_q <= base_q + PTR_ONE;
                            end else begin
                                depth_q <= depth_q + DEPTH_ONE;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (pop) begin
                        if (is_empty) begin
                            err_q <= 1'b1;
                        end else begin
                            top_q   <= top_q - PTR_ONE;
                            depth_q <= depth_q - DEPTH_ONE;
                            addr_q  <= top_q - PTR_ONE;
                            state_q <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: state_q <= RD_DATA;
                RD_DATA: begin
                    board_out_q <= mem_dout;
                    valid_q     <= 1'b1;
                    state_q     <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign board_out   = board_out_q;
    assign board_valid = valid_q;
    assign busy        = (state_q != IDLE);
    assign depth       = depth_q;
    assign empty       = is_empty;
    assign full        = is_full;
    assign err         = err_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_din     = din_q;

endmodule

// File: tb/tb_board_history_stack.sv
// Directed bench: reject-when-full and circular instances share one stimulus
// stream, each backed by its own registered-read BRAM model.
module tb_board_history_stack;

    localparam int W  = 256;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic          pop;
    logic          clear;
    logic [W-1:0]  boardIn;

    logic [W-1:0]  boardOut0, boardOut1;
    logic          boardValid0, boardValid1;
    logic          busy0, busy1;
    logic [AW:0]   depth0, depth1;
    logic          empty0, empty1;
    logic          full0, full1;
    logic          err0, err1;
    logic          memWe0, memWe1;
    logic [AW-1:0] memAddr0, memAddr1;
    logic [W-1:0]  memDin0, memDin1;
    logic [W-1:0]  memDout0, memDout1;

    logic [W-1:0]  ram0 [16];
    logic [W-1:0]  ram1 [16];
    logic [AW-1:0] rdAddr0, rdAddr1;

    int nAssert = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    board_history_stack #(.MEM_SIZE(W), .DEPTH_LOG2(AW), .WRAP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .clear(clear),
        .board_in(boardIn), .board_out(boardOut0), .board_valid(boardValid0),
        .busy(busy0), .depth(depth0), .empty(empty0), .full(full0), .err(err0),
        .mem_we(memWe0), .mem_addr(memAddr0), .mem_din(memDin0), .mem_dout(memDout0)
    );

    board_history_stack #(.MEM_SIZE(W), .DEPTH_LOG2(AW), .WRAP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .clear(clear),
        .board_in(boardIn), .board_out(boardOut1), .board_valid(boardValid1),
        .busy(busy1), .depth(depth1), .empty(empty1), .full(full1), .err(err1),
        .mem_we(memWe1), .mem_addr(memAddr1), .mem_din(memDin1), .mem_dout(memDout1)
    );

    // BRAM models: write on the edge, address registered, data out next cycle.
    always @(posedge clk) begin
        if (memWe0) ram0[memAddr0] <= memDin0;
        if (memWe1) ram1[memAddr1] <= memDin1;
        rdAddr0 <= memAddr0;
        rdAddr1 <= memAddr1;
    end
    assign memDout0 = ram0[rdAddr0];
    assign memDout1 = ram1[rdAddr1];

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        nAssert++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of requests, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic p, input logic q, input logic c, input logic [W-1:0] d);
        push    = p;
        pop     = q;
        clear   = c;
        boardIn = d;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        reset = 1'b0;
    endtask

    // Accept edge -> RD_ADDR -> RD_DATA -> DONE (valid) -> IDLE.
    task automatic popBoth(input logic [W-1:0] exp0, input logic [W-1:0] exp1, input logic [AW:0] dep);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("popBusy0", busy0, 1);
        checkOutput("popBusy1", busy1, 1);
        checkOutput("popDepth0", depth0, dep);
        checkOutput("popDepth1", depth1, dep);
        checkOutput("popNoWe0", memWe0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("popEarlyValid0", boardValid0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("popValid0", boardValid0, 1);
        checkOutput("popValid1", boardValid1, 1);
        checkOutput("popData0", boardOut0, exp0);
        checkOutput("popData1", boardOut1, exp1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("popIdle0", busy0, 0);
        checkOutput("popValidDrop0", boardValid0, 0);
    endtask

    initial begin
        reset   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
        boardIn = '0;
        #1;
        doReset();

        checkOutput("rstBoardOut", boardOut0, 0);
        checkOutput("rstValid", boardValid0, 0);
        checkOutput("rstBusy", busy0, 0);
        checkOutput("rstDepth", depth0, 0);
        checkOutput("rstEmpty", empty0, 1);
        checkOutput("rstFull", full0, 0);
        checkOutput("rstErr", err0, 0);
        checkOutput("rstWe", memWe0, 0);
        checkOutput("rstAddr", memAddr0, 0);
        checkOutput("rstDin", memDin0, 0);

        // Single push: registered write strobe the cycle after accept.
        applyStimulus(1'b1, 1'b0, 1'b0, 256'h1);
        checkOutput("push1We", memWe0, 1);
        checkOutput("push1Addr", memAddr0, 0);
        checkOutput("push1Din", memDin0, 256'h1);
        checkOutput("push1Depth", depth0, 1);
        checkOutput("push1Empty", empty0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("push1WePulse", memWe0, 0);

        // Back-to-back pushes then two pops.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 256'hA);
        checkOutput("pushAAddr", memAddr0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 256'hB);
        checkOutput("pushBAddr", memAddr0, 1);
        checkOutput("pushBWe", memWe0, 1);
        checkOutput("pushBDepth", depth0, 2);
        popBoth(256'hB, 256'hB, 1);
        checkOutput("popBAddr", memAddr0, 1);
        popBoth(256'hA, 256'hA, 0);
        checkOutput("popAEmpty", empty0, 1);

        // Pop when empty: err pulse, no access, board_out held.
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("popEmptyErr", err0, 1);
        checkOutput("popEmptyBusy", busy0, 0);
        checkOutput("popEmptyWe", memWe0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("popEmptyErrPulse", err0, 0);
        checkOutput("popEmptyHold", boardOut0, 256'hA);
        checkOutput("popEmptyNoValid", boardValid0, 0);

        // Fill to capacity, then overflow push.
        doReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, W'(i));
        end
        checkOutput("fillFull0", full0, 1);
        checkOutput("fillFull1", full1, 1);
        checkOutput("fillDepth0", depth0, 16);
        applyStimulus(1'b1, 1'b0, 1'b0, W'(16));
        checkOutput("ovfErr0", err0, 1);
        checkOutput("ovfWe0", memWe0, 0);
        checkOutput("ovfErr1", err1, 0);
        checkOutput("ovfWe1", memWe1, 1);
        checkOutput("ovfAddr1", memAddr1, 0);
        checkOutput("ovfDin1", memDin1, 16);
        checkOutput("ovfDepth1", depth1, 16);
        checkOutput("ovfDepth0", depth0, 16);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("ovfErrPulse0", err0, 0);
        for (int i = 0; i < 16; i++) begin
            popBoth(W'(15 - i), W'(16 - i), 5'(15 - i));
        end
        checkOutput("drainEmpty0", empty0, 1);
        checkOutput("drainEmpty1", empty1, 1);
        checkOutput("drainFull1", full1, 0);

        // Reset asserted during RD_DATA aborts the pop.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 256'h55);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("abortInRdData", busy0, 1);
        reset = 1'b1;
        #1;
        checkOutput("abortBusy", busy0, 0);
        checkOutput("abortDepth", depth0, 0);
        checkOutput("abortEmpty", empty0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("abortNoValid", boardValid0, 0);
        checkOutput("abortBoardOut", boardOut0, 0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("abortStillNoValid", boardValid0, 0);

        // Priority: push beats pop, clear beats push.
        applyStimulus(1'b1, 1'b1, 1'b0, 256'h77);
        checkOutput("pushPopBusy", busy0, 0);
        checkOutput("pushPopDepth", depth0, 1);
        checkOutput("pushPopWe", memWe0, 1);
        checkOutput("pushPopDin", memDin0, 256'h77);
        checkOutput("pushPopErr", err0, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 256'h88);
        checkOutput("clearDepth", depth0, 0);
        checkOutput("clearWe", memWe0, 0);
        checkOutput("clearEmpty", empty0, 1);
        checkOutput("clearBoardOut", boardOut0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
